decrypt_pipe_expand: RTL and testbench

Front stage of the decrypt pipeline. It takes one ASCII byte per cycle, classifies it as upper-case, lower-case or other, and converts letters into the 32-bit extended one-hot word consumed by `decrypt_pipe_shift`. It also selects a per-character shift amount from a loaded multi-digit key. All outputs are registered and wire directly to the matching inputs of `decrypt_pipe_shift`.

---
 rtl/decrypt_pipe_expand.sv | 120 ++++++++++++
 tb/tb_decrypt_pipe_expand.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/decrypt_pipe_expand.sv
// rtl/decrypt_pipe_expand.sv - ASCII classify, one-hot letter expansion and per-character key digit selection
// DECRYPT_KEY_ROTATE_EN defined: key pointer rotates (Vigenere); undefined: digit 0 only (Caesar).
module decrypt_pipe_expand #(
   parameter int KEY_LEN = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        mode,
   input  logic [7:0]  data_in,
   input  logic        key_load,
   input  logic [23:0] key_in,
   input  logic        restart,
   output logic        en_out,
   output logic        mode_out,
   output logic        shift_en,
   output logic [2:0]  shift_amt,
   output logic [31:0] extended_shift_in,
   output logic        is_alpha_upper_case,
   output logic        is_alpha_low_case,
   output logic        key_err
);

`ifdef DECRYPT_KEY_ROTATE_EN
   localparam int CHK_LEN = KEY_LEN;
`else
   localparam int CHK_LEN = 1;
`endif

   logic [23:0] key;
   logic [2:0]  ptr;
   logic [2:0]  ptr_next;
   logic        upper;
   logic        lower;
   logic        letter;
   logic        shift_now;
   logic [4:0]  idx;
   logic [4:0]  digit_base;
   logic [2:0]  digit;
   logic        key_ok;
   logic [31:0] ext_next;

   assign upper      = (data_in >= 8'd65) && (data_in <= 8'd90);
   assign lower      = (data_in >= 8'd97) && (data_in <= 8'd122);
   assign letter     = upper | lower;
   assign shift_now  = en & mode & letter;
   // 'A' and 'a' both have low five bits 00001, so one subtract covers both cases
   assign idx        = data_in[4:0] - 5'd1;
   assign digit_base = {2'b00, ptr} * 5'd3;
   assign digit      = key[digit_base +: 3];

   always_comb begin
      key_ok = 1'b1;
      for (int d = 0; d < 8; d++) begin
         if (d < CHK_LEN && key_in[3*d +: 3] == 3'd7)
            key_ok = 1'b0;
      end
   end

   always_comb begin
      ext_next = 32'd0;
      if (shift_now)
         ext_next = 32'd1 << ({1'b0, idx} + 6'd6);
      else if (en)
         ext_next = {24'd0, data_in};
   end

`ifdef DECRYPT_KEY_ROTATE_EN
   always_comb begin
      ptr_next = ptr;
      if (restart || (key_load && key_ok))
         ptr_next = 3'd0;
      else if (shift_now)
         ptr_next = (ptr == 3'(KEY_LEN - 1)) ? 3'd0 : ptr + 3'd1;
   end
`else
   logic unused_restart;
   assign unused_restart = restart;
   assign ptr_next       = 3'd0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         key     <= 24'd0;
         ptr     <= 3'd0;
         key_err <= 1'b0;
      end else begin
         ptr <= ptr_next;
         if (key_load) begin
            if (key_ok) begin
               key     <= key_in;
               key_err <= 1'b0;
            end else begin
               key_err <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         en_out              <= 1'b0;
         mode_out            <= 1'b0;
         shift_en            <= 1'b0;
         shift_amt           <= 3'd0;
         extended_shift_in   <= 32'd0;
         is_alpha_upper_case <= 1'b0;
         is_alpha_low_case   <= 1'b0;
      end else begin
         en_out              <= en;
         mode_out            <= mode;
         shift_en            <= shift_now;
         shift_amt           <= shift_now ? digit : 3'd0;
         extended_shift_in   <= ext_next;
         is_alpha_upper_case <= en & upper;
         is_alpha_low_case   <= en & lower;
      end
   end

endmodule

// File: tb/tb_decrypt_pipe_expand.sv
// tb/tb_decrypt_pipe_expand.sv - randomized and directed check of decrypt_pipe_expand against a reference model
module tb_decrypt_pipe_expand;
   localparam int KL = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic        mode = 1'b0;
   logic [7:0]  data_in = 8'd0;
   logic        key_load = 1'b0;
   logic [23:0] key_in = 24'd0;
   logic        restart = 1'b0;
   logic        en_out;
   logic        mode_out;
   logic        shift_en;
   logic [2:0]  shift_amt;
   logic [31:0] extended_shift_in;
   logic        is_alpha_upper_case;
   logic        is_alpha_low_case;
   logic        key_err;

   int checks = 0;
   int failures = 0;

   int key_m [8];
   int ptr_m;
   bit err_m;

   decrypt_pipe_expand #(.KEY_LEN(KL)) dut (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .data_in(data_in),
      .key_load(key_load), .key_in(key_in), .restart(restart),
      .en_out(en_out), .mode_out(mode_out), .shift_en(shift_en),
      .shift_amt(shift_amt), .extended_shift_in(extended_shift_in),
      .is_alpha_upper_case(is_alpha_upper_case),
      .is_alpha_low_case(is_alpha_low_case), .key_err(key_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 8; d++) key_m[d] = 0;
      ptr_m = 0;
      err_m = 0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_en_out"}, 32'(en_out), 0);
      check({tag, "_mode_out"}, 32'(mode_out), 0);
      check({tag, "_shift_en"}, 32'(shift_en), 0);
      check({tag, "_shift_amt"}, 32'(shift_amt), 0);
      check({tag, "_ext"}, extended_shift_in, 0);
      check({tag, "_upper"}, 32'(is_alpha_upper_case), 0);
      check({tag, "_lower"}, 32'(is_alpha_low_case), 0);
      check({tag, "_key_err"}, 32'(key_err), 0);
   endtask

   // One input cycle: drive, predict from the model, clock, compare, advance the model.
   task automatic step(input bit e, input bit m, input int d, input bit kl, input int k, input bit rs);
      bit up, lo, sh, legal;
      int nchk, amt, e_ext, e_up, e_lo;
      en = e; mode = m; data_in = 8'(d); key_load = kl; key_in = 24'(k); restart = rs;
      up = (d >= 65 && d <= 90);
      lo = (d >= 97 && d <= 122);
      sh = e && m && (up || lo);
      amt = sh ? key_m[ptr_m] : 0;
      if (!e) e_ext = 0;
      else if (sh) e_ext = 1 << (6 + (up ? d - 65 : d - 97));
      else e_ext = d;
      e_up = e && up;
      e_lo = e && lo;
`ifdef DECRYPT_KEY_ROTATE_EN
      nchk = KL;
`else
      nchk = 1;
`endif
      legal = 1;
      for (int i = 0; i < nchk; i++) if (((k >> (3 * i)) & 7) == 7) legal = 0;
      if (kl) begin
         if (legal) begin
            for (int i = 0; i < 8; i++) key_m[i] = (k >> (3 * i)) & 7;
            err_m = 0;
         end else begin
            err_m = 1;
         end
      end
`ifdef DECRYPT_KEY_ROTATE_EN
      if (rs || (kl && legal)) ptr_m = 0;
      else if (sh) ptr_m = (ptr_m + 1) % KL;
`else
      ptr_m = 0;
`endif
      @(posedge clk);
      #1;
      check("en_out", 32'(en_out), 32'(e));
      check("mode_out", 32'(mode_out), 32'(m));
      check("shift_en", 32'(shift_en), 32'(sh));
      check("shift_amt", 32'(shift_amt), 32'(amt));
      check("ext", extended_shift_in, 32'(e_ext));
      check("upper", 32'(is_alpha_upper_case), 32'(e_up));
      check("lower", 32'(is_alpha_low_case), 32'(e_lo));
      check("key_err", 32'(key_err), 32'(err_m));
   endtask

   function automatic int rand_char();
      int r = $urandom_range(0, 9);
      if (r < 4) return $urandom_range(65, 90);
      if (r < 8) return $urandom_range(97, 122);
      return $urandom_range(0, 255);
   endfunction

   initial begin
      int exp_a [3];
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst = 1'b0;

      // 'D' with the reset key
      step(1, 1, 68, 0, 0, 0);
      check("t1_ext", extended_shift_in, 32'h0000_0200);
      check("t1_amt", 32'(shift_amt), 0);
      check("t1_upper", 32'(is_alpha_upper_case), 1);

      // key {3,1}, three 'd'
`ifdef DECRYPT_KEY_ROTATE_EN
      exp_a = '{3, 1, 3};
`else
      exp_a = '{3, 3, 3};
`endif
      step(0, 0, 0, 1, 3 | (1 << 3), 0);
      for (int i = 0; i < 3; i++) begin
         step(1, 1, 100, 0, 0, 0);
         check("t2_amt", 32'(shift_amt), 32'(exp_a[i]));
      end

      // key {2,5}: 'a', '#', 'b'
      step(0, 0, 0, 1, 2 | (5 << 3), 0);
      step(1, 1, 97, 0, 0, 0);
      check("t3_a_amt", 32'(shift_amt), 2);
      step(1, 1, 35, 0, 0, 0);
      check("t3_hash_ext", extended_shift_in, 35);
      check("t3_hash_sh", 32'(shift_en), 0);
      step(1, 1, 98, 0, 0, 0);
`ifdef DECRYPT_KEY_ROTATE_EN
      check("t3_b_amt", 32'(shift_amt), 5);
`else
      check("t3_b_amt", 32'(shift_amt), 2);
`endif

      // illegal load keeps key {2,5}, legal load clears the flag
      step(0, 0, 0, 1, 7 | (1 << 3), 0);
      check("t4_err", 32'(key_err), 1);
      step(1, 1, 120, 0, 0, 0);
      check("t4_old_key", 32'(shift_amt), 2);
      step(0, 0, 0, 1, 4 | (6 << 3), 0);
      check("t4_err_clr", 32'(key_err), 0);

      // restart together with a letter while ptr = 1
      step(1, 1, 65, 0, 0, 0);
      step(1, 1, 66, 0, 0, 1);
`ifdef DECRYPT_KEY_ROTATE_EN
      check("t5_restart_amt", 32'(shift_amt), 6);
`else
      check("t5_restart_amt", 32'(shift_amt), 4);
`endif
      step(1, 1, 67, 0, 0, 0);
      check("t5_after_amt", 32'(shift_amt), 4);

      // bypass 'Q', then asynchronous reset mid-stream
      step(1, 0, 81, 0, 0, 0);
      check("t6_ext", extended_shift_in, 81);
      check("t6_sh", 32'(shift_en), 0);
      step(0, 0, 0, 1, 7, 0);
      en = 1'b1; mode = 1'b1; data_in = 8'd90; key_load = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check_all_zero("async_rst");
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      step(1, 1, 90, 0, 0, 0);
      check("post_rst_amt", 32'(shift_amt), 0);

      for (int n = 0; n < 600; n++) begin
         int k = 0;
         for (int i = 0; i < 8; i++) k |= ($urandom_range(0, 9) == 0 ? 7 : $urandom_range(0, 6)) << (3 * i);
         step($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 8, rand_char(),
              $urandom_range(0, 19) == 0, k, $urandom_range(0, 19) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
